// File: rtl/arbitro_vc_destino_pkg.sv
// Shared definitions for the VC-to-destination arbiter and the control FSM
// status decoding that reads its state.
package arbitro_vc_destino_pkg;

    // Arbiter state encoding, also decoded by the control FSM.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GNT_VC0 = 2'b01,
        ST_GNT_VC1 = 2'b10
    } arb_state_e;

    // Data word width of the switch datapath.
    localparam int ARB_BW       = 6;
    // Head-word bit that selects the destination FIFO (0 -> D0, 1 -> D1).
    localparam int ARB_DEST_BIT = 4;
    // Width of the consecutive-VC0-grant counter.
    localparam int ARB_CNT_W    = 4;

endpackage : arbitro_vc_destino_pkg

// File: rtl/arbitro_vc_destino.sv
// Scheduler between the two virtual-channel FIFOs and the two destination
// FIFOs. At most one head word is popped per cycle. That word is pushed into
// its destination one cycle later. VC0 has priority, but a consecutive-grant
// counter forces a VC1 grant after MAX_CONSEC VC0 grants while VC1 waits.
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | no grant was issued in the previous cycle
// ST_GNT_VC0 | VC0 was granted in the previous cycle
// ST_GNT_VC1 | VC1 was granted in the previous cycle
module arbitro_vc_destino
    import arbitro_vc_destino_pkg::*;
#(
    parameter int BW         = ARB_BW,
    parameter int DEST_BIT   = ARB_DEST_BIT,
    parameter int MAX_CONSEC = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    input  logic          vc0_empty,
    input  logic          vc1_empty,
    input  logic [BW-1:0] vc0_data,
    input  logic [BW-1:0] vc1_data,
    input  logic          d0_almost_full,
    input  logic          d1_almost_full,
    output logic          pop_vc0,
    output logic          pop_vc1,
    output logic          push_d0,
    output logic          push_d1,
    output logic [BW-1:0] data_out,
    output logic [1:0]    arb_state
);

    localparam logic [ARB_CNT_W-1:0] MAX_CNT = ARB_CNT_W'(MAX_CONSEC);

    logic                 elig0;
    logic                 elig1;
    logic                 gnt0;
    logic                 gnt1;
    logic                 dest0;
    logic                 dest1;

    logic [ARB_CNT_W-1:0] cnt_q;
    logic [ARB_CNT_W-1:0] cnt_d;
    logic                 push_d0_q;
    logic                 push_d0_d;
    logic                 push_d1_q;
    logic                 push_d1_d;
    logic [BW-1:0]        data_out_q;
    logic [BW-1:0]        data_out_d;
    arb_state_e           state_q;
    arb_state_e           state_d;

    // Eligibility and grant selection. Reset masks eligibility so no pop
    // escapes while reset is held.
    always_comb begin
        dest0 = vc0_data[DEST_BIT];
        dest1 = vc1_data[DEST_BIT];
        elig0 = active & ~reset & ~vc0_empty
              & ~(dest0 ? d1_almost_full : d0_almost_full);
        elig1 = active & ~reset & ~vc1_empty
              & ~(dest1 ? d1_almost_full : d0_almost_full);
        gnt0  = elig0 & (~elig1 | (cnt_q < MAX_CNT));
        gnt1  = elig1 & ~gnt0;
    end

    // Next values for the push stage and the consecutive-grant counter.
    always_comb begin
        push_d0_d  = 1'b0;
        push_d1_d  = 1'b0;
        data_out_d = data_out_q;
        cnt_d      = cnt_q;
        if (gnt0) begin
            data_out_d = vc0_data;
            push_d0_d  = ~dest0;
            push_d1_d  = dest0;
            if (elig1 && (cnt_q < MAX_CNT)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (gnt1) begin
            data_out_d = vc1_data;
            push_d0_d  = ~dest1;
            push_d1_d  = dest1;
            cnt_d      = '0;
        end
    end

    // Push stage and counter registers; reset drops any in-flight push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_d0_q  <= 1'b0;
            push_d1_q  <= 1'b0;
            data_out_q <= '0;
            cnt_q      <= '0;
        end else begin
            push_d0_q  <= push_d0_d;
            push_d1_q  <= push_d1_d;
            data_out_q <= data_out_d;
            cnt_q      <= cnt_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state follows the grant issued this cycle.
    always_comb begin
        state_d = ST_IDLE;
        if (gnt0) begin
            state_d = ST_GNT_VC0;
        end else if (gnt1) begin
            state_d = ST_GNT_VC1;
        end
    end

    // FSM and datapath outputs; pops are combinational with the grant.
    always_comb begin
        pop_vc0   = gnt0;
        pop_vc1   = gnt1;
        push_d0   = push_d0_q;
        push_d1   = push_d1_q;
        data_out  = data_out_q;
        arb_state = state_q;
    end

endmodule : arbitro_vc_destino

// File: tb/tb_arbitro_vc_destino.sv
// Directed bench for the VC-to-destination arbiter.
module tb_arbitro_vc_destino;

    logic       clk;
    logic       reset;
    logic       active;
    logic       vc0_empty;
    logic       vc1_empty;
    logic [5:0] vc0_data;
    logic [5:0] vc1_data;
    logic       d0_almost_full;
    logic       d1_almost_full;
    logic       pop_vc0;
    logic       pop_vc1;
    logic       push_d0;
    logic       push_d1;
    logic [5:0] data_out;
    logic [1:0] arb_state;

    int errors = 0;
    int checks = 0;

    arbitro_vc_destino #(.BW(6), .DEST_BIT(4), .MAX_CONSEC(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .active        (active),
        .vc0_empty     (vc0_empty),
        .vc1_empty     (vc1_empty),
        .vc0_data      (vc0_data),
        .vc1_data      (vc1_data),
        .d0_almost_full(d0_almost_full),
        .d1_almost_full(d1_almost_full),
        .pop_vc0       (pop_vc0),
        .pop_vc1       (pop_vc1),
        .push_d0       (push_d0),
        .push_d1       (push_d1),
        .data_out      (data_out),
        .arb_state     (arb_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; active = 1'b1;
        vc0_empty = 1'b0; vc0_data = 6'h05;
        vc1_empty = 1'b1; vc1_data = 6'h00;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({pop_vc0, pop_vc1, push_d0, push_d1} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_quiet cyc%0d: pops/pushes=%b expected 0000", i,
                         {pop_vc0, pop_vc1, push_d0, push_d1});
            end
            checks++;
            if (arb_state !== 2'b00 || data_out !== 6'h00) begin
                errors++;
                $display("FAIL reset_state: arb_state=%b data_out=%h expected 00/00",
                         arb_state, data_out);
            end
            tick();
        end
        reset = 1'b0;
        #1;
        checks++;
        if (pop_vc0 !== 1'b1 || pop_vc1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_pop: pop_vc0=%b pop_vc1=%b expected 1/0", pop_vc0, pop_vc1);
        end
        tick();
        vc0_empty = 1'b1;
        checks++;
        if (push_d0 !== 1'b1 || push_d1 !== 1'b0 || data_out !== 6'h05 || arb_state !== 2'b01) begin
            errors++;
            $display("FAIL reset_release_push: push_d0=%b push_d1=%b data=%h state=%b expected 1/0/05/01",
                     push_d0, push_d1, data_out, arb_state);
        end
        #1;
        checks++;
        if (pop_vc0 !== 1'b0) begin
            errors++;
            $display("FAIL empty_no_pop: pop_vc0=%b expected 0", pop_vc0);
        end
        tick();
        checks++;
        if (push_d0 !== 1'b0 || data_out !== 6'h05 || arb_state !== 2'b00) begin
            errors++;
            $display("FAIL idle_hold: push_d0=%b data=%h state=%b expected 0/05/00",
                     push_d0, data_out, arb_state);
        end
    endtask

    // Both VCs always eligible: VC0 x4 then VC1 x1, repeating.
    task automatic test_fairness();
        logic [9:0] exp_g1;
        exp_g1 = 10'b1000010000;  // bit i = VC1 granted on cycle i
        vc0_empty = 1'b0; vc0_data = 6'h01;
        vc1_empty = 1'b0; vc1_data = 6'h12;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (pop_vc1 !== exp_g1[i] || pop_vc0 !== ~exp_g1[i]) begin
                errors++;
                $display("FAIL fair_pop cyc%0d: pop_vc0=%b pop_vc1=%b expected %b/%b", i,
                         pop_vc0, pop_vc1, ~exp_g1[i], exp_g1[i]);
            end
            tick();
            checks++;
            if (push_d1 !== exp_g1[i] || push_d0 !== ~exp_g1[i] ||
                data_out !== (exp_g1[i] ? 6'h12 : 6'h01) ||
                arb_state !== (exp_g1[i] ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL fair_push cyc%0d: d0=%b d1=%b data=%h state=%b", i,
                         push_d0, push_d1, data_out, arb_state);
            end
        end
    endtask

    // VC0 blocked on D0, VC1 to free D1: VC1 served every cycle.
    task automatic test_no_hol();
        vc0_data = 6'h01; vc1_data = 6'h13; d0_almost_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b1) begin
                errors++;
                $display("FAIL hol_pop cyc%0d: pop_vc0=%b pop_vc1=%b expected 0/1", i, pop_vc0, pop_vc1);
            end
            tick();
            checks++;
            if (push_d1 !== 1'b1 || push_d0 !== 1'b0 || data_out !== 6'h13 || arb_state !== 2'b10) begin
                errors++;
                $display("FAIL hol_push cyc%0d: d0=%b d1=%b data=%h state=%b expected 0/1/13/10", i,
                         push_d0, push_d1, data_out, arb_state);
            end
        end
        d0_almost_full = 1'b0;
    endtask

    // Counter primed to 2, then both blocked on D1: counter must hold,
    // so after unblocking only two more VC0 grants precede VC1.
    task automatic test_same_full_dest();
        logic [4:0] exp_g1;
        vc0_data = 6'h11; vc1_data = 6'h12;
        tick();
        tick();
        d1_almost_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (pop_vc0 !== 1'b0 || pop_vc1 !== 1'b0) begin
                errors++;
                $display("FAIL full_pop cyc%0d: pop_vc0=%b pop_vc1=%b expected 0/0", i, pop_vc0, pop_vc1);
            end
            tick();
            checks++;
            if (arb_state !== 2'b00 || push_d0 !== 1'b0 || push_d1 !== 1'b0) begin
                errors++;
                $display("FAIL full_idle cyc%0d: state=%b d0=%b d1=%b expected 00/0/0", i,
                         arb_state, push_d0, push_d1);
            end
        end
        d1_almost_full = 1'b0;
        exp_g1 = 5'b00100;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (pop_vc1 !== exp_g1[i] || pop_vc0 !== ~exp_g1[i]) begin
                errors++;
                $display("FAIL full_resume cyc%0d: pop_vc0=%b pop_vc1=%b expected %b/%b", i,
                         pop_vc0, pop_vc1, ~exp_g1[i], exp_g1[i]);
            end
            tick();
        end
        checks++;
        if (push_d1 !== 1'b1 || data_out !== 6'h12) begin
            errors++;
            $display("FAIL full_resume_push: d1=%b data=%h expected 1/12", push_d1, data_out);
        end
    endtask

    // active drops after a grant: that push completes, nothing new popped.
    task automatic test_active_drop();
        vc0_data = 6'h07; vc1_empty = 1'b1;
        #1;
        checks++;
        if (pop_vc0 !== 1'b1) begin
            errors++;
            $display("FAIL act_pop: pop_vc0=%b expected 1", pop_vc0);
        end
        tick();
        active = 1'b0;
        #1;
        checks++;
        if (push_d0 !== 1'b1 || data_out !== 6'h07 || pop_vc0 !== 1'b0) begin
            errors++;
            $display("FAIL act_push: d0=%b data=%h pop_vc0=%b expected 1/07/0", push_d0, data_out, pop_vc0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (push_d0 !== 1'b0 || pop_vc0 !== 1'b0 || arb_state !== 2'b00) begin
                errors++;
                $display("FAIL act_quiet cyc%0d: d0=%b pop_vc0=%b state=%b expected 0/0/00", i,
                         push_d0, pop_vc0, arb_state);
            end
        end
    endtask

    // Reset between grant and push drops the push and clears the counter.
    task automatic test_reset_midflight();
        logic [4:0] exp_g1;
        active = 1'b1; vc0_data = 6'h0A; vc1_empty = 1'b0; vc1_data = 6'h15;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (push_d0 !== 1'b0 || push_d1 !== 1'b0 || data_out !== 6'h00 || arb_state !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid: d0=%b d1=%b data=%h state=%b expected 0/0/00/00",
                     push_d0, push_d1, data_out, arb_state);
        end
        tick();
        reset = 1'b0;
        exp_g1 = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (pop_vc1 !== exp_g1[i] || pop_vc0 !== ~exp_g1[i]) begin
                errors++;
                $display("FAIL rst_cnt cyc%0d: pop_vc0=%b pop_vc1=%b expected %b/%b", i,
                         pop_vc0, pop_vc1, ~exp_g1[i], exp_g1[i]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_no_hol();
        test_same_full_dest();
        test_active_drop();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_arbitro_vc_destino

// File: doc/arbitro_vc_destino.md
Name: arbitro_vc_destino

Overview:
- Scheduler between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the switch.
- Each cycle it picks at most one VC head word whose destination FIFO has room, pops it, and pushes it into D0 or D1 one cycle later.
- VC0 has priority; a consecutive-grant counter guarantees VC1 forward progress.
- Enabled only while the control FSM reports the active state.

Parameters:
- BW, 6, data word width.
- DEST_BIT, 4, bit of the head word selecting the destination (0 → D0, 1 → D1).
- MAX_CONSEC, 4, maximum consecutive VC0 grants while VC1 is eligible before VC1 is forced; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- active  in  1  control FSM is in active state; arbitration permitted only when 1.
- vc0_empty  in  1  VC0 FIFO empty.
- vc1_empty  in  1  VC1 FIFO empty.
- vc0_data  in  BW  VC0 head word (show-ahead FIFO).
- vc1_data  in  BW  VC1 head word (show-ahead FIFO).
- d0_almost_full  in  1  D0 at or above its almost-full threshold.
- d1_almost_full  in  1  D1 at or above its almost-full threshold.
- pop_vc0  out  1  pop VC0 this cycle (combinational).
- pop_vc1  out  1  pop VC1 this cycle (combinational).
- push_d0  out  1  push data_out into D0 (registered).
- push_d1  out  1  push data_out into D1 (registered).
- data_out  out  BW  word being pushed (registered).
- arb_state  out  2  FSM state: 00 IDLE, 01 GNT_VC0, 10 GNT_VC1.

Behaviour:
- Reset (async, high): push_d0/d1 = 0, data_out = 0, consec counter = 0, state IDLE. pop_vc0/1 = 0 while reset is high.
- Eligibility, combinational per cycle:
  - eligX = active & !vcX_empty & !almost_full of the FIFO chosen by vcX_data[DEST_BIT].
- Selection:
  - If elig0 & (!elig1 | cnt < MAX_CONSEC) → grant VC0.
  - Else if elig1 → grant VC1.
  - Else no grant.
  - At most one pop per cycle; pop_vcX = grant to X in the same cycle.
- Push timing: on the edge that ends a grant cycle, register data_out = granted head word, push_dY = 1 for its destination, other push = 0. With no grant, both pushes = 0 and data_out holds its value. Latency pop → push is exactly 1 cycle.
- Counter behaviour:
  - VC0 grant with elig1 = 1: increment, saturating at MAX_CONSEC.
  - VC0 grant with elig1 = 0: counter holds.
  - VC1 grant: clear to 0.
  - No grant: counter holds.
- FSM, registered: next state = GNT_VC0 / GNT_VC1 / IDLE following the grant of the current cycle. arb_state reflects the last cycle's grant.
- Backpressure: almost-full thresholds are sized to absorb the one in-flight word. The arbiter never checks full.
- Boundary cases:
  - Both VCs target the same full destination: no grant, counter holds.
  - VC0 blocked on D0 while VC1 targets free D1: VC1 granted immediately, no head-of-line blocking across VCs.
  - active falls mid-stream: no new pops from that cycle on; a push already registered still completes on the next cycle.
  - reset asserted mid-transfer: the in-flight push is dropped, all state cleared immediately.
  - vcX_empty rising in the same cycle as eligibility: treated as not eligible.
- Widths: counter is 4 bits; DEST_BIT < BW.

Decomposition:
- Shared package:
  - state encodings IDLE/GNT_VC0/GNT_VC1 (shared with the control FSM's status decoding);
  - BW default;
  - DEST_BIT position.
- Single module. A separate sub-module is not warranted; eligibility and grant logic stay in one combinational block plus one registered block.

Test Plan:
- Reset high, VC0 non-empty, active = 1 → pops and pushes stay 0, arb_state = 00. Release reset → pop_vc0 next eval cycle, push_d0 one cycle later with data_out = 6'h05 (head 6'h05, DEST_BIT = 0).
- Both VCs continuously non-empty, all destinations free, MAX_CONSEC = 4 → grant sequence VC0×4, VC1×1, repeating; counter returns to 0 after each VC1 grant.
- VC0 head → D0 with d0_almost_full = 1, VC1 head → D1 free → pop_vc1 every cycle, pop_vc0 = 0, push_d1 = 1 one cycle later.
- Both heads → D1 with d1_almost_full = 1 → no pops, arb_state → 00. Deassert almost_full → VC0 granted first.
- active dropped on the cycle after a VC0 grant → that push_d0 still appears, then no further pops while active = 0.
- reset pulsed between a grant and its push → push suppressed, data_out = 0, counter = 0.
